// File: rtl/axi4_lite_req_arbiter_pkg.sv
// Shared definitions for the AXI4-Lite request arbiter.
//   arb_state_t     : arbiter FSM state encoding
//   AXI_RESP_*      : AXI response codes used by the arbiter
//   PROT_DEFAULT    : value driven on AWPROT/ARPROT
package axi4_lite_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_WR      = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD      = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_DONE    = 3'd6
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [2:0] PROT_DEFAULT    = 3'b000;

endpackage

// File: rtl/axi4_lite_req_arbiter_rr_select.sv
// Combinational round-robin selector.
//   i_req : request vector, one bit per requester
//   i_ptr : index where the upward scan starts (wraps at NUM_REQ)
//   o_any : at least one request is pending
//   o_idx : index of the first pending request at or above i_ptr
module axi4_lite_rr_select
  import axi4_lite_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_any,
  output logic [IDX_W-1:0]   o_idx
);

  int unsigned w_j;

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    w_j   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = (32'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[IDX_W'(w_j)]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Shares one AXI4-Lite master port among NUM_REQ requesters.
//   req_*        : per-requester command (valid/write/addr/wdata/wstrb), flattened
//   req_ready    : one-cycle pulse when the winner's command is captured
//   resp_valid   : one-cycle pulse when the winner's command completes
//   resp_rdata/resp_code : shared completion data, held until the next completion
//   M_AXI_*      : AXI4-Lite master channels; all outputs registered
// One transaction outstanding at a time; round-robin fairness via rr pointer.
module axi4_lite_req_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 6
) (
  input  logic                                       M_AXI_ACLK,
  input  logic                                       M_AXI_ARESETN,
  input  logic [NUM_REQ-1:0]                         req_valid,
  input  logic [NUM_REQ-1:0]                         req_write,
  input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0]      req_wdata,
  input  logic [NUM_REQ*(C_M_AXI_DATA_WIDTH/8)-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]                         req_ready,
  output logic [NUM_REQ-1:0]                         resp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]              resp_rdata,
  output logic [1:0]                                 resp_code,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_AWADDR,
  output logic [2:0]                                 M_AXI_AWPROT,
  output logic                                       M_AXI_AWVALID,
  input  logic                                       M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]            M_AXI_WSTRB,
  output logic                                       M_AXI_WVALID,
  input  logic                                       M_AXI_WREADY,
  input  logic [1:0]                                 M_AXI_BRESP,
  input  logic                                       M_AXI_BVALID,
  output logic                                       M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_ARADDR,
  output logic [2:0]                                 M_AXI_ARPROT,
  output logic                                       M_AXI_ARVALID,
  input  logic                                       M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_RDATA,
  input  logic [1:0]                                 M_AXI_RRESP,
  input  logic                                       M_AXI_RVALID,
  output logic                                       M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t r_state, w_state_nxt;

  logic [IW-1:0]      r_grant, w_grant_nxt;
  logic [IW-1:0]      r_ptr, w_ptr_nxt;
  logic               r_write, w_write_nxt;
  logic [AW-1:0]      r_addr, w_addr_nxt;
  logic [DW-1:0]      r_wdata, w_wdata_nxt;
  logic [SW-1:0]      r_wstrb, w_wstrb_nxt;
  logic               r_awvalid, w_awvalid_nxt;
  logic               r_wvalid, w_wvalid_nxt;
  logic               r_bready, w_bready_nxt;
  logic               r_arvalid, w_arvalid_nxt;
  logic               r_rready, w_rready_nxt;
  logic               r_aw_done, w_aw_done_nxt;
  logic               r_w_done, w_w_done_nxt;
  logic               r_ar_done, w_ar_done_nxt;
  logic [NUM_REQ-1:0] r_req_ready, w_req_ready_nxt;
  logic [NUM_REQ-1:0] r_resp_valid, w_resp_valid_nxt;
  logic [DW-1:0]      r_resp_rdata, w_resp_rdata_nxt;
  logic [1:0]         r_resp_code, w_resp_code_nxt;

  logic          w_any;
  logic [IW-1:0] w_sel;
  logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic          w_aw_fin, w_w_fin, w_ar_fin;

  axi4_lite_rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_rr_select (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_sel)
  );

  assign w_aw_hs  = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs   = r_wvalid  & M_AXI_WREADY;
  assign w_b_hs   = r_bready  & M_AXI_BVALID;
  assign w_ar_hs  = r_arvalid & M_AXI_ARREADY;
  assign w_r_hs   = r_rready  & M_AXI_RVALID;
  // A slave may raise READY before VALID, so handshakes can already
  // complete in GRANT; the done flags remember them across states.
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done  | w_w_hs;
  assign w_ar_fin = r_ar_done | w_ar_hs;

  // State register
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_any) w_state_nxt = ST_GRANT;
      ST_GRANT:   w_state_nxt = r_write ? ST_WR : ST_RD;
      ST_WR:      if (w_aw_fin && w_w_fin) w_state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (w_b_hs) w_state_nxt = ST_DONE;
      ST_RD:      if (w_ar_fin) w_state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (w_r_hs) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and capture regs
  always_comb begin
    w_grant_nxt      = r_grant;
    w_ptr_nxt        = r_ptr;
    w_write_nxt      = r_write;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_wstrb_nxt      = r_wstrb;
    w_awvalid_nxt    = r_awvalid;
    w_wvalid_nxt     = r_wvalid;
    w_bready_nxt     = r_bready;
    w_arvalid_nxt    = r_arvalid;
    w_rready_nxt     = r_rready;
    w_aw_done_nxt    = r_aw_done;
    w_w_done_nxt     = r_w_done;
    w_ar_done_nxt    = r_ar_done;
    w_req_ready_nxt  = '0;
    w_resp_valid_nxt = '0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_code_nxt  = r_resp_code;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant_nxt     = w_sel;
          w_write_nxt     = req_write[w_sel];
          w_addr_nxt      = req_addr[w_sel*AW +: AW];
          w_wdata_nxt     = req_wdata[w_sel*DW +: DW];
          w_wstrb_nxt     = req_wstrb[w_sel*SW +: SW];
          w_req_ready_nxt = ONE << w_sel;
          w_awvalid_nxt   = req_write[w_sel];
          w_wvalid_nxt    = req_write[w_sel];
          w_arvalid_nxt   = ~req_write[w_sel];
          w_aw_done_nxt   = 1'b0;
          w_w_done_nxt    = 1'b0;
          w_ar_done_nxt   = 1'b0;
        end
      end
      ST_GRANT, ST_WR, ST_RD: begin
        if (w_aw_hs) begin
          w_awvalid_nxt = 1'b0;
          w_aw_done_nxt = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
          w_w_done_nxt = 1'b1;
        end
        if (w_ar_hs) begin
          w_arvalid_nxt = 1'b0;
          w_ar_done_nxt = 1'b1;
        end
        if (w_state_nxt == ST_WR_RESP) w_bready_nxt = 1'b1;
        if (w_state_nxt == ST_RD_DATA) w_rready_nxt = 1'b1;
      end
      ST_WR_RESP: begin
        if (w_b_hs) begin
          w_bready_nxt     = 1'b0;
          w_resp_code_nxt  = M_AXI_BRESP;
          w_resp_rdata_nxt = '0;
          w_resp_valid_nxt = ONE << r_grant;
        end
      end
      ST_RD_DATA: begin
        if (w_r_hs) begin
          w_rready_nxt     = 1'b0;
          w_resp_code_nxt  = M_AXI_RRESP;
          w_resp_rdata_nxt = M_AXI_RDATA;
          w_resp_valid_nxt = ONE << r_grant;
        end
      end
      ST_DONE: begin
        w_ptr_nxt = (r_grant == IW'(NUM_REQ-1)) ? '0 : r_grant + 1'b1;
      end
      default: ;
    endcase
  end

  // Output and capture registers
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_grant      <= '0;
      r_ptr        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_ar_done    <= 1'b0;
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_resp_rdata <= '0;
      r_resp_code  <= AXI_RESP_OKAY;
    end else begin
      r_grant      <= w_grant_nxt;
      r_ptr        <= w_ptr_nxt;
      r_write      <= w_write_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wstrb      <= w_wstrb_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_bready     <= w_bready_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_rready     <= w_rready_nxt;
      r_aw_done    <= w_aw_done_nxt;
      r_w_done     <= w_w_done_nxt;
      r_ar_done    <= w_ar_done_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_code  <= w_resp_code_nxt;
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_code     = r_resp_code;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Directed testbench for axi4_lite_req_arbiter with a small AXI4-Lite
// register slave (16 x 32-bit words, configurable READY/RVALID stalls).
module tb_axi4_lite_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic [3:0]   req_valid, req_write;
  logic [23:0]  req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wstrb;
  logic [3:0]   req_ready, resp_valid;
  logic [31:0]  resp_rdata;
  logic [1:0]   resp_code;
  logic [5:0]   AWADDR, ARADDR;
  logic [2:0]   AWPROT, ARPROT;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]  WDATA, RDATA;
  logic [3:0]   WSTRB;
  logic [1:0]   BRESP, RRESP;

  axi4_lite_req_arbiter #(
    .NUM_REQ            (4),
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_WIDTH (6)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rstn),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_code     (resp_code),
    .M_AXI_AWADDR  (AWADDR),
    .M_AXI_AWPROT  (AWPROT),
    .M_AXI_AWVALID (AWVALID),
    .M_AXI_AWREADY (AWREADY),
    .M_AXI_WDATA   (WDATA),
    .M_AXI_WSTRB   (WSTRB),
    .M_AXI_WVALID  (WVALID),
    .M_AXI_WREADY  (WREADY),
    .M_AXI_BRESP   (BRESP),
    .M_AXI_BVALID  (BVALID),
    .M_AXI_BREADY  (BREADY),
    .M_AXI_ARADDR  (ARADDR),
    .M_AXI_ARPROT  (ARPROT),
    .M_AXI_ARVALID (ARVALID),
    .M_AXI_ARREADY (ARREADY),
    .M_AXI_RDATA   (RDATA),
    .M_AXI_RRESP   (RRESP),
    .M_AXI_RVALID  (RVALID),
    .M_AXI_RREADY  (RREADY)
  );

  // ---------------- slave model ----------------
  int          cfg_aw_stall = 0;
  int          cfg_w_stall  = 0;
  int          cfg_r_stall  = 0;
  logic        cfg_rerr     = 1'b0;
  logic [31:0] mem [0:15];
  logic [63:0] write_val;
  logic        aw_have, w_have, r_pend;
  logic [5:0]  aw_addr_q, r_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  int          aw_wait, w_wait, r_wait;
  int          b_cnt  = 0;
  int          ar_cnt = 0;

  wire         s_aw_hs = AWREADY & AWVALID;
  wire         s_w_hs  = WREADY & WVALID;
  wire         s_ar_hs = ARREADY & ARVALID;
  wire         s_aw_ok = aw_have | s_aw_hs;
  wire         s_w_ok  = w_have | s_w_hs;
  wire [3:0]   s_widx  = aw_have ? aw_addr_q[5:2] : AWADDR[5:2];
  wire [31:0]  s_wd    = w_have ? w_data_q : WDATA;
  wire [3:0]   s_ws    = w_have ? w_strb_q : WSTRB;

  assign write_val = {mem[1], mem[0]};
  assign BRESP     = 2'b00;

  function automatic logic [31:0] smask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      AWREADY <= 1'b0; WREADY <= 1'b0; BVALID <= 1'b0;
      ARREADY <= 1'b0; RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
      aw_have <= 1'b0; w_have <= 1'b0; r_pend <= 1'b0;
      aw_wait <= 0; w_wait <= 0; r_wait <= 0;
      aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0; r_addr_q <= '0;
      for (int k = 0; k < 16; k++) mem[k] <= 32'h1000_0000 + k;
    end else begin
      if (AWREADY) AWREADY <= 1'b0;
      else if (AWVALID && !aw_have) begin
        if (aw_wait == cfg_aw_stall) AWREADY <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end
      if (WREADY) WREADY <= 1'b0;
      else if (WVALID && !w_have) begin
        if (w_wait == cfg_w_stall) WREADY <= 1'b1;
        else w_wait <= w_wait + 1;
      end
      if (s_aw_hs) aw_wait <= 0;
      if (s_w_hs)  w_wait  <= 0;
      if (s_aw_ok && s_w_ok && !BVALID) begin
        mem[s_widx] <= (mem[s_widx] & ~smask(s_ws)) | (s_wd & smask(s_ws));
        BVALID  <= 1'b1;
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end else begin
        if (s_aw_hs) begin aw_have <= 1'b1; aw_addr_q <= AWADDR; end
        if (s_w_hs)  begin w_have <= 1'b1; w_data_q <= WDATA; w_strb_q <= WSTRB; end
      end
      if (BVALID && BREADY) begin BVALID <= 1'b0; b_cnt <= b_cnt + 1; end
      if (ARREADY) ARREADY <= 1'b0;
      else if (ARVALID) ARREADY <= 1'b1;
      if (s_ar_hs) begin
        r_pend <= 1'b1; r_wait <= 0; r_addr_q <= ARADDR; ar_cnt <= ar_cnt + 1;
      end else if (r_pend && !RVALID) begin
        if (r_wait == cfg_r_stall) begin
          RVALID <= 1'b1;
          RDATA  <= mem[r_addr_q[5:2]];
          RRESP  <= cfg_rerr ? 2'b10 : 2'b00;
          r_pend <= 1'b0;
        end else r_wait <= r_wait + 1;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  logic [3:0]  grant_q[$];
  logic [3:0]  ridx_q[$];
  logic [31:0] rdata_q[$];
  logic [1:0]  rcode_q[$];
  int          resp_cnt = 0;
  int          aw_only  = 0;

  function automatic logic [3:0] oh2idx(input logic [3:0] v);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  always @(negedge clk) begin
    if (req_ready != 4'b0) grant_q.push_back(oh2idx(req_ready));
    if (resp_valid != 4'b0) begin
      ridx_q.push_back(oh2idx(resp_valid));
      rdata_q.push_back(resp_rdata);
      rcode_q.push_back(resp_code);
      resp_cnt <= resp_cnt + 1;
    end
    if (AWVALID && !WVALID) aw_only <= aw_only + 1;
  end

  // ---------------- checking helpers ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic drop_acked();
    for (int i = 0; i < 4; i++) if (req_ready[i]) req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic wr, input logic [5:0] a, input logic [31:0] d);
    req_valid[i]           = 1'b1;
    req_write[i]           = wr;
    req_addr[i*6 +: 6]     = a;
    req_wdata[i*32 +: 32]  = d;
    req_wstrb[i*4 +: 4]    = 4'hF;
  endtask

  task automatic serve(input int n, input int budget);
    int target;
    target = resp_cnt + n;
    for (int c = 0; c < budget; c++) begin
      tick();
      drop_acked();
      if (resp_cnt >= target) return;
    end
    chk("serve_timeout", 64'(resp_cnt), 64'(target));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  int n0, base_a, base_b, base_r, base_g;

  initial begin
    rstn = 1'b0; req_valid = '0; req_write = '0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_valid_ready", {59'b0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 64'h0);
    chk("rst_req_resp", {56'b0, req_ready, resp_valid}, 64'h0);
    chk("rst_resp_data", {30'b0, resp_code, resp_rdata}, 64'h0);
    chk("rst_axi_payload", {16'b0, AWADDR, ARADDR, WDATA, WSTRB}, 64'h0);
    rstn = 1'b1;
    tick();

    // Single write from requester 2, cycle-accurate
    issue(2, 1'b1, 6'h04, 32'hDEADBEEF);
    tick();
    chk("wr_c1_req_ready", req_ready, 4'b0100);
    chk("wr_c1_aw_w_valid", {AWVALID, WVALID, ARVALID}, 3'b110);
    chk("wr_c1_awaddr", AWADDR, 6'h04);
    chk("wr_c1_wdata", {WSTRB, WDATA}, {4'hF, 32'hDEADBEEF});
    drop_acked();
    tick();
    chk("wr_c2", {req_ready, AWVALID, WVALID, BREADY}, {4'b0, 3'b110});
    tick();
    chk("wr_c3_bready", {AWVALID, WVALID, BREADY, resp_valid}, {3'b001, 4'b0});
    tick();
    chk("wr_c4_resp_valid", resp_valid, 4'b0100);
    chk("wr_c4_resp", {resp_code, resp_rdata}, 34'h0);
    tick();
    chk("wr_c5_resp_clear", {BREADY, resp_valid}, 5'b0);
    chk("wr_write_val_hi", write_val[63:32], 32'hDEADBEEF);

    // Single read from requester 0
    issue(0, 1'b0, 6'h04, 32'h0);
    serve(1, 30);
    chk("rd_resp_idx", ridx_q[$], 4'd0);
    chk("rd_resp_data", rdata_q[$], 32'hDEADBEEF);
    chk("rd_resp_code", rcode_q[$], 2'b00);

    // Round-robin from reset
    do_reset();
    n0 = grant_q.size();
    issue(0, 1'b0, 6'h00, 0); issue(1, 1'b0, 6'h04, 0);
    issue(2, 1'b0, 6'h08, 0); issue(3, 1'b0, 6'h0C, 0);
    serve(4, 80);
    chk("rr_order_0123", {grant_q[n0], grant_q[n0+1], grant_q[n0+2], grant_q[n0+3]}, 16'h0123);
    chk("rr_resp_order", {ridx_q[$-3], ridx_q[$-2], ridx_q[$-1], ridx_q[$]}, 16'h0123);
    chk("rr_data_req2", rdata_q[$-1], 32'h1000_0002);
    // Pointer back at 0: 1 wins over 3
    n0 = grant_q.size();
    issue(3, 1'b0, 6'h00, 0); issue(1, 1'b0, 6'h00, 0);
    serve(2, 40);
    chk("rr_ptr0_order_13", {grant_q[n0], grant_q[n0+1]}, 8'h13);
    // Serve 1 alone -> pointer 2; then 3 wins over 0
    issue(1, 1'b0, 6'h00, 0);
    serve(1, 30);
    n0 = grant_q.size();
    issue(0, 1'b0, 6'h00, 0); issue(3, 1'b0, 6'h00, 0);
    serve(2, 40);
    chk("rr_ptr2_order_30", {grant_q[n0], grant_q[n0+1]}, 8'h30);

    // Independent AW/W: AWREADY stalled 3 cycles beyond WREADY
    cfg_aw_stall = 3;
    base_a = aw_only; base_b = b_cnt;
    issue(1, 1'b1, 6'h08, 32'h1234_5678);
    serve(1, 40);
    repeat (3) tick();
    chk("aw_w_aw_only_cycles", 64'(aw_only - base_a), 64'd3);
    chk("aw_w_b_count", 64'(b_cnt - base_b), 64'd1);
    chk("aw_w_mem", mem[2], 32'h1234_5678);
    chk("aw_w_resp", {ridx_q[$], rcode_q[$]}, {4'd1, 2'b00});
    cfg_aw_stall = 0;

    // Error response, no retry
    cfg_rerr = 1'b1;
    base_a = ar_cnt; base_g = grant_q.size();
    issue(3, 1'b0, 6'h00, 0);
    serve(1, 30);
    repeat (5) tick();
    chk("err_resp_idx_code", {ridx_q[$], rcode_q[$]}, {4'd3, 2'b10});
    chk("err_resp_data", rdata_q[$], 32'h1000_0000);
    chk("err_no_retry_ar", 64'(ar_cnt - base_a), 64'd1);
    chk("err_no_retry_grant", 64'(grant_q.size() - base_g), 64'd1);
    cfg_rerr = 1'b0;

    // Reset in RD_DATA
    cfg_r_stall = 5;
    base_r = resp_cnt;
    issue(2, 1'b0, 6'h04, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      drop_acked();
      if (RREADY) break;
    end
    chk("mid_rd_reached_rd_data", RREADY, 1'b1);
    rstn = 1'b0;
    tick();
    chk("mid_rst_valid_ready", {59'b0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 64'h0);
    chk("mid_rst_req_resp", {56'b0, req_ready, resp_valid}, 64'h0);
    chk("mid_rst_resp_data", {30'b0, resp_code, resp_rdata}, 64'h0);
    chk("mid_rst_araddr", ARADDR, 6'h0);
    rstn = 1'b1;
    cfg_r_stall = 0;
    repeat (10) tick();
    chk("mid_rst_no_resp", 64'(resp_cnt - base_r), 64'd0);
    issue(1, 1'b0, 6'h00, 0);
    serve(1, 30);
    chk("post_rst_resp", {ridx_q[$], rcode_q[$], rdata_q[$]}, {4'd1, 2'b00, 32'h1000_0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_req_arbiter.md
# axi4_lite_req_arbiter

Shares one AXI4-Lite master port among `NUM_REQ` internal requesters, such as the gate-control, statistics and CPU-bridge engines, which need register access to a single AXI4-Lite register slave. Each requester issues one read or write command over a simple valid/ready interface. The block picks one command round-robin, runs the full AXI4-Lite transaction, and returns read data and response to the winner. Only one AXI transaction is outstanding at any time.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `C_M_AXI_DATA_WIDTH`, 32: AXI data width (32 or 64).
- `C_M_AXI_ADDR_WIDTH`, 6: AXI address width; matches the slave.
- `M_AXI_ACLK`  in  1  the only clock.
- `M_AXI_ARESETN`  in  1  reset; synchronous and active-low.
- `req_valid`  in  NUM_REQ  per-requester command pending.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*AW  flattened byte addresses; requester i occupies `[i*AW +: AW]`.
- `req_wdata`  in  NUM_REQ*DW  flattened write data.
- `req_wstrb`  in  NUM_REQ*DW/8  flattened byte strobes.
- `req_ready`  out  NUM_REQ  one-cycle pulse: the command has been captured.
- `resp_valid`  out  NUM_REQ  one-cycle pulse: the command has completed.
- `resp_rdata`  out  DW  read data; shared, valid with `resp_valid`.
- `resp_code`  out  2  BRESP or RRESP; shared, valid with `resp_valid`.
- `M_AXI_AWADDR/AWPROT/AWVALID/AWREADY`, `WDATA/WSTRB/WVALID/WREADY`, `BRESP/BVALID/BREADY`, `ARADDR/ARPROT/ARVALID/ARREADY`, `RDATA/RRESP/RVALID/RREADY`: standard AXI4-Lite master channels. `AWPROT` and `ARPROT` are tied to `3'b000`.

## Operation
- States: IDLE, GRANT, WR, WR_RESP, RD, RD_DATA, DONE.
- IDLE, when any `req_valid` is high:
  - Select the first set bit scanning upward from `rr_ptr`, wrapping at NUM_REQ.
  - Register the grant index `g` and capture write/addr/wdata/wstrb for `g`.
  - Go to GRANT.
- GRANT (1 cycle):
  - Pulse `req_ready[g]`.
  - For a write, assert `AWVALID` and `WVALID` together, then go to WR.
  - For a read, assert `ARVALID`, then go to RD.
- WR: each of AW and W deasserts independently on its own handshake. When both handshakes are done, including in the same cycle, assert `BREADY` and go to WR_RESP.
- WR_RESP: on `BVALID & BREADY`, latch `BRESP` into `resp_code`, set `resp_rdata` = 0, and go to DONE.
- RD: on `ARVALID & ARREADY`, drop `ARVALID`, assert `RREADY`, and go to RD_DATA.
- RD_DATA: on `RVALID & RREADY`, latch `RDATA` and `RRESP`, and go to DONE.
- DONE (1 cycle):
  - Pulse `resp_valid[g]`.
  - Set `rr_ptr` = (g+1) mod NUM_REQ.
  - Return to IDLE.
- Requester rule: hold `req_valid` and the command fields stable until `req_ready`. Dropping `req_valid` earlier is a protocol violation; the block does not detect it.
- A requester may reassert `req_valid` from the cycle after its `req_ready`. It is not granted again while another requester is waiting.
- AXI outputs never depend combinationally on AXI inputs. All outputs are registered.
- `resp_rdata` and `resp_code` hold their value until the next DONE.

## Timing
- Reset values:
  - Every `*VALID`, `*READY`, `req_ready` and `resp_valid` output is 0.
  - `resp_rdata`, `resp_code`, `AWADDR`, `ARADDR`, `WDATA` and `WSTRB` are 0.
  - `rr_ptr` = 0; state = IDLE.
- Reset asserted mid-transaction: the block returns to IDLE on the next edge and emits no `resp_valid`. The slave shares this reset and is reset with it.
- Request sampled in IDLE at cycle 0: `req_ready` and AXI VALID at cycle 1.
- A write to a slave that accepts AW and W together one cycle after VALID and returns BVALID the following cycle:
  - B handshake at cycle 3, `resp_valid` at cycle 4.
  - The next grant is sampled at cycle 5.
- With an ideal slave, the minimum period is 5 cycles for a write and 5 cycles for a read.
- A simultaneous `req_valid` from every requester is served in rotating order. There is no starvation: the worst-case wait is (NUM_REQ-1) transactions.

## Structure
- Shared package `axi4_lite_arb_pkg`:
  - state encoding;
  - `AXI_RESP_OKAY=2'b00` and `AXI_RESP_SLVERR=2'b10`;
  - `PROT_DEFAULT=3'b000`.
- Sub-module `axi4_lite_rr_select`, purely combinational:
  - inputs: request vector and `rr_ptr`;
  - outputs: `any` and the grant index.
- The top level holds the FSM, the capture registers and the AXI channel registers.

## Test plan
- **Single write.** Reset. Requester 2 writes addr 0x04, data 0xDEADBEEF, strb 0xF. Expect, in order:
  - one `req_ready[2]` pulse;
  - AW and W carrying 0x04 and 0xDEADBEEF;
  - `resp_valid[2]` with `resp_code` = 0;
  - slave `write_val[63:32]` = 0xDEADBEEF.
- **Single read.** Requester 0 reads back 0x04. Expect `resp_valid[0]` with `resp_rdata` = 0xDEADBEEF and `resp_code` = 0.
- **Round-robin.** All four requesters assert reads together from reset. Expect grant order 0,1,2,3, then `rr_ptr` = 0. After `rr_ptr` = 2, requesters 0 and 3 request together: expect 3 granted before 0.
- **Independent AW/W.** The slave stalls AWREADY 3 cycles after WREADY. Expect WVALID to drop after its handshake while AWVALID holds, and exactly one B accepted.
- **Error response.** The slave returns RRESP = 2'b10. Expect `resp_code` = 2'b10 on the granted requester and no retry.
- **Reset mid-read.** Pull `M_AXI_ARESETN` low while in RD_DATA. Expect:
  - all outputs at reset values the next cycle;
  - no `resp_valid`;
  - the next request is served normally.
